// File: rtl/lc3_decode_ctrl_if.sv
// Signal bundle between the LC3 per-instruction sequencer and its surroundings
// (instruction memory, execute unit, fetch).
interface lc3_decode_ctrl_if;
  logic        start;
  logic [15:0] mem_dout;
  logic        exec_done;
  logic        fetch_start;
  logic [3:0]  opCode_out;
  logic [8:0]  offset_out;
  logic [2:0]  br_nzp_out;
  logic [2:0]  dr_out;
  logic [2:0]  sr1_out;
  logic [2:0]  sr2_out;
  logic        imm_flag;
  logic [4:0]  imm5_out;
  logic [15:0] ir_out;
  logic        exec_start;
  logic        busy;
  logic        halt;
  logic [15:0] instr_cnt;

  // Sequencer side
  modport slave (
    input  start, mem_dout, exec_done,
    output fetch_start, opCode_out, offset_out, br_nzp_out, dr_out, sr1_out,
           sr2_out, imm_flag, imm5_out, ir_out, exec_start, busy, halt, instr_cnt
  );

  // Environment side
  modport master (
    output start, mem_dout, exec_done,
    input  fetch_start, opCode_out, offset_out, br_nzp_out, dr_out, sr1_out,
           sr2_out, imm_flag, imm5_out, ir_out, exec_start, busy, halt, instr_cnt
  );
endinterface

// File: rtl/lc3_decode_ctrl.sv
// LC3 per-instruction sequencer: waits out the memory latency, loads IR, decodes it,
// hands off to the execute unit and then pulses fetch_start to advance the PC.
module lc3_decode_ctrl #(
  parameter int MEM_LAT = 1  // legal 1..7
) (
  input  logic              clk,
  input  logic              rst_n,
  lc3_decode_ctrl_if.slave  ctrl
);

  localparam logic [2:0]  LAT_M1    = 3'(MEM_LAT - 1);
  localparam logic [15:0] TRAP_HALT = 16'hF025;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_NEXT,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [2:0]  r_lat;
  logic [15:0] r_ir;
  logic [15:0] r_instr_cnt;
  logic        r_exec_start;
  logic        r_fetch_start;
  logic        r_busy;
  logic        r_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_lat         <= 3'd0;
      r_ir          <= 16'h0000;
      r_instr_cnt   <= 16'h0000;
      r_exec_start  <= 1'b0;
      r_fetch_start <= 1'b0;
      r_busy        <= 1'b0;
      r_halt        <= 1'b0;
    end else begin
      // Both handshake pulses are single-cycle unless re-armed below.
      r_exec_start  <= 1'b0;
      r_fetch_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl.start) begin
            r_state <= S_FETCH;
            r_lat   <= LAT_M1;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (r_lat == 3'd0) begin
            r_ir <= ctrl.mem_dout;
            if (ctrl.mem_dout == TRAP_HALT) begin
              r_state <= S_HALT;
              r_busy  <= 1'b0;
              r_halt  <= 1'b1;
            end else begin
              r_state      <= S_EXEC;
              r_exec_start <= 1'b1;
            end
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end
        S_EXEC: begin
          if (ctrl.exec_done) begin
            r_state       <= S_NEXT;
            r_fetch_start <= 1'b1;
          end
        end
        S_NEXT: begin
          r_state     <= S_FETCH;
          r_lat       <= LAT_M1;
          r_instr_cnt <= r_instr_cnt + 16'd1;
        end
        S_HALT: begin
          r_halt <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  // Decoded fields are plain slices of IR, so they only move when IR is loaded.
  assign ctrl.opCode_out  = r_ir[15:12];
  assign ctrl.br_nzp_out  = r_ir[11:9];
  assign ctrl.dr_out      = r_ir[11:9];
  assign ctrl.sr1_out     = r_ir[8:6];
  assign ctrl.sr2_out     = r_ir[2:0];
  assign ctrl.imm_flag    = r_ir[5];
  assign ctrl.imm5_out    = r_ir[4:0];
  assign ctrl.offset_out  = r_ir[8:0];
  assign ctrl.ir_out      = r_ir;
  assign ctrl.exec_start  = r_exec_start;
  assign ctrl.fetch_start = r_fetch_start;
  assign ctrl.busy        = r_busy;
  assign ctrl.halt        = r_halt;
  assign ctrl.instr_cnt   = r_instr_cnt;

endmodule

// File: tb/tb_lc3_decode_ctrl.sv
// Self-checking bench for lc3_decode_ctrl: a per-cycle timeline model built from
// instruction-level rules, driven against MEM_LAT=1 and MEM_LAT=3 instances.
module tb_lc3_decode_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lc3_decode_ctrl_if bus1();
  lc3_decode_ctrl_if bus3();

  lc3_decode_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .ctrl(bus1.slave));
  lc3_decode_ctrl #(.MEM_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .ctrl(bus3.slave));

  typedef struct {
    logic [3:0] op;
    logic [2:0] nzp;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic       imm;
    logic [4:0] imm5;
    logic [8:0] off;
  } fld_t;

  typedef struct {
    logic [15:0] word;
    int          d;
    fld_t        f;
  } vec_t;

  typedef struct {
    logic        start;
    logic        done;
    logic [15:0] mem;
    logic        es;
    logic        fs;
    logic        busy;
    logic        halt;
    logic [15:0] ir;
    logic [15:0] cnt;
    fld_t        f;
  } cyc_t;

  typedef struct {
    logic        es;
    logic        fs;
    logic        busy;
    logic        halt;
    logic [15:0] ir;
    logic [15:0] cnt;
    logic [30:0] flds;
  } obs_t;

  int checks = 0;
  int errors = 0;

  cyc_t        tl[$];
  logic [15:0] m_ir;
  logic [15:0] m_cnt;
  fld_t        m_f;
  vec_t        tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic fld_t mkf(input logic [15:0] w);
    fld_t f;
    f.op   = w[15:12];
    f.nzp  = w[11:9];
    f.sr1  = w[8:6];
    f.sr2  = w[2:0];
    f.imm  = w[5];
    f.imm5 = w[4:0];
    f.off  = w[8:0];
    return f;
  endfunction

  function automatic logic [30:0] fpack(input fld_t f);
    return {f.op, f.nzp, f.nzp, f.sr1, f.sr2, f.imm, f.imm5, f.off};
  endfunction

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) begin
      o.es = bus3.exec_start; o.fs = bus3.fetch_start; o.busy = bus3.busy; o.halt = bus3.halt;
      o.ir = bus3.ir_out; o.cnt = bus3.instr_cnt;
      o.flds = {bus3.opCode_out, bus3.br_nzp_out, bus3.dr_out, bus3.sr1_out, bus3.sr2_out,
                bus3.imm_flag, bus3.imm5_out, bus3.offset_out};
    end else begin
      o.es = bus1.exec_start; o.fs = bus1.fetch_start; o.busy = bus1.busy; o.halt = bus1.halt;
      o.ir = bus1.ir_out; o.cnt = bus1.instr_cnt;
      o.flds = {bus1.opCode_out, bus1.br_nzp_out, bus1.dr_out, bus1.sr1_out, bus1.sr2_out,
                bus1.imm_flag, bus1.imm5_out, bus1.offset_out};
    end
    return o;
  endfunction

  task automatic drive(input bit sel, input logic st, input logic dn, input logic [15:0] mem);
    if (sel) begin
      bus3.start = st; bus3.exec_done = dn; bus3.mem_dout = mem;
    end else begin
      bus1.start = st; bus1.exec_done = dn; bus1.mem_dout = mem;
    end
  endtask

  task automatic chk_zero(input string tag, input bit sel);
    obs_t o;
    o = sample(sel);
    chk({tag, ".ctrl"},   32'({o.es, o.fs, o.busy, o.halt}), 32'h0);
    chk({tag, ".ir"},     32'(o.ir), 32'h0);
    chk({tag, ".cnt"},    32'(o.cnt), 32'h0);
    chk({tag, ".fields"}, 32'(o.flds), 32'h0);
  endtask

  task automatic model_clear();
    m_ir  = 16'h0000;
    m_cnt = 16'h0000;
    m_f   = mkf(16'h0000);
    tl.delete();
  endtask

  task automatic push(input logic st, input logic dn, input logic [15:0] mem,
                      input logic es, input logic fs, input logic bz, input logic hl);
    cyc_t c;
    c.start = st; c.done = dn; c.mem = mem;
    c.es = es; c.fs = fs; c.busy = bz; c.halt = hl;
    c.ir = m_ir; c.cnt = m_cnt; c.f = m_f;
    tl.push_back(c);
  endtask

  // Idle cycles; when go is set, start is raised in the last one.
  task automatic add_idle(input int n, input bit go);
    for (int j = 0; j < n; j++)
      push(go && (j == n - 1), 1'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One instruction: lat FETCH cycles, d+1 EXEC cycles, one NEXT cycle (or halt).
  task automatic add_instr(input int lat, input logic [15:0] w, input int d,
                           input fld_t f, input bit rnd);
    for (int j = 0; j < lat; j++)
      push(1'($urandom), 1'($urandom), (j == lat - 1) ? w : (rnd ? 16'($urandom) : 16'hFFFF),
           1'b0, 1'b0, 1'b1, 1'b0);
    m_ir = w;
    m_f  = f;
    if (w != 16'hF025) begin
      for (int j = 0; j <= d; j++)
        push(1'($urandom), (j == d), 16'($urandom), (j == 0), 1'b0, 1'b1, 1'b0);
      push(1'($urandom), 1'($urandom), 16'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  task automatic add_halt(input int n);
    for (int j = 0; j < n; j++)
      push(1'($urandom), 1'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_tl(input bit sel, input string tag);
    obs_t o;
    foreach (tl[i]) begin
      @(negedge clk);
      o = sample(sel);
      chk($sformatf("%s.c%0d.ctrl", tag, i), 32'({o.es, o.fs, o.busy, o.halt}),
          32'({tl[i].es, tl[i].fs, tl[i].busy, tl[i].halt}));
      chk($sformatf("%s.c%0d.ir", tag, i), 32'(o.ir), 32'(tl[i].ir));
      chk($sformatf("%s.c%0d.cnt", tag, i), 32'(o.cnt), 32'(tl[i].cnt));
      chk($sformatf("%s.c%0d.fields", tag, i), 32'(o.flds), 32'(fpack(tl[i].f)));
      drive(sel, tl[i].start, tl[i].done, tl[i].mem);
    end
    tl.delete();
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    chk_zero({tag, ".rst1"}, 1'b0);
    chk_zero({tag, ".rst3"}, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Launch one instruction on dut1 and wait (bounded) until its EXEC cycle is visible.
  task automatic start_and_wait_exec(input string tag, input logic [15:0] w);
    int n;
    add_idle(2, 1'b1);
    run_tl(1'b0, {tag, ".pre"});
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, w);
    n = 0;
    while (!bus1.exec_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".exec_seen"}, 32'(bus1.exec_start), 32'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    tbl[0] = '{16'h1261, 3, '{4'h1, 3'd1, 3'd1, 3'd1, 1'b1, 5'h01, 9'h061}};
    tbl[1] = '{16'h0E05, 0, '{4'h0, 3'd7, 3'd0, 3'd5, 1'b0, 5'h05, 9'h005}};
    tbl[2] = '{16'h5FBF, 1, '{4'h5, 3'd7, 3'd6, 3'd7, 1'b1, 5'h1F, 9'h1BF}};
    tbl[3] = '{16'hD123, 2, '{4'hD, 3'd0, 3'd4, 3'd3, 1'b1, 5'h03, 9'h123}};
    tbl[4] = '{16'h1A82, 4, '{4'h1, 3'd5, 3'd2, 3'd2, 1'b0, 5'h02, 9'h082}};
    rst_n = 1'b1;
    model_clear();

    // Idle after reset with exec_done toggling
    do_reset("idle");
    add_idle(10, 1'b0);
    run_tl(1'b0, "idle");

    // Table of decoded instructions, back to back, closed with TRAP HALT
    do_reset("tbl");
    add_idle(2, 1'b1);
    for (int k = 0; k < 5; k++)
      add_instr(1, tbl[k].word, tbl[k].d, tbl[k].f, 1'b1);
    add_instr(1, 16'hF025, 0, mkf(16'hF025), 1'b1);
    add_halt(5);
    run_tl(1'b0, "tbl");

    // Halt straight from reset: 20 quiet cycles
    do_reset("halt");
    add_idle(3, 1'b1);
    add_instr(1, 16'hF025, 0, mkf(16'hF025), 1'b1);
    add_halt(20);
    run_tl(1'b0, "halt");

    // MEM_LAT=3 with 0xFFFF until the capture cycle
    do_reset("lat3");
    add_idle(2, 1'b1);
    add_instr(3, 16'h1261, 2, mkf(16'h1261), 1'b0);
    add_instr(3, 16'h0E05, 0, mkf(16'h0E05), 1'b0);
    add_instr(3, 16'hF025, 0, mkf(16'hF025), 1'b0);
    add_halt(4);
    run_tl(1'b1, "lat3");

    // Reset dropped in EXEC: outputs clear at once, nothing pending afterwards
    do_reset("rstx");
    start_and_wait_exec("rstx", 16'h1261);
    #2;
    rst_n = 1'b0;
    bus1.exec_done = 1'b1;
    #1;
    chk_zero("rstx.async", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    add_idle(8, 1'b0);
    run_tl(1'b0, "rstx.after");

    // instr_cnt wrap 0xFFFF -> 0x0000
    do_reset("wrap");
    start_and_wait_exec("wrap", 16'h1261);
    force dut1.r_instr_cnt = 16'hFFFF;
    @(negedge clk);
    release dut1.r_instr_cnt;
    @(negedge clk);
    chk("wrap.cnt_pre", 32'(bus1.instr_cnt), 32'hFFFF);
    bus1.exec_done = 1'b1;
    @(negedge clk);
    chk("wrap.fs", 32'({bus1.fetch_start, bus1.exec_start}), 32'h2);
    chk("wrap.cnt_next", 32'(bus1.instr_cnt), 32'hFFFF);
    bus1.exec_done = 1'b0;
    @(negedge clk);
    chk("wrap.cnt_post", 32'(bus1.instr_cnt), 32'h0000);
    chk("wrap.fs_off", 32'(bus1.fetch_start), 32'h0);

    // Random programs on both latencies
    for (int r = 0; r < 4; r++) begin
      bit sel;
      int lat;
      sel = (r == 3);
      lat = sel ? 3 : 1;
      do_reset($sformatf("rnd%0d", r));
      add_idle(1 + int'($urandom_range(0, 3)), 1'b1);
      for (int k = 0; k < 30; k++) begin
        w = 16'($urandom);
        if (w == 16'hF025) w = 16'hF024;
        add_instr(lat, w, int'($urandom_range(0, 4)), mkf(w), 1'b1);
      end
      add_instr(lat, 16'hF025, 0, mkf(16'hF025), 1'b1);
      add_halt(3);
      run_tl(sel, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
